// File: rtl/mapping_weight_sequencer.sv
// Sweeps the mapping-layer weight ROM and unpacks each 24-bit word, MSB byte first,
// into a valid/ready stream of signed 8-bit weights, repeating once per channel pass.
module mapping_weight_sequencer #(
  parameter int NUM_WORDS = 6,
  parameter int ADDR_W    = 3,
  parameter int PASS_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [PASS_W-1:0]       cfg_passes,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [23:0]             rom_dout,
  output logic signed [7:0]       w_data,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic                    w_last,
  output logic [1:0]              w_idx,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   word_cnt;
  logic [1:0]          byte_cnt;
  logic [PASS_W-1:0]   pass_cnt;
  logic [PASS_W-1:0]   passes_q;
  logic signed [23:0]  hold;
  logic                hs;
  logic                last_byte;
  logic                last_word;
  logic                last_pass;

  function automatic logic signed [7:0] lane_sel(input logic signed [23:0] word,
                                                 input logic [1:0] idx);
    case (idx)
      2'd0:    return $signed(word[23:16]);
      2'd1:    return $signed(word[15:8]);
      default: return $signed(word[7:0]);
    endcase
  endfunction

  assign hs        = (state == EMIT) && w_ready;
  assign last_byte = (byte_cnt == 2'd2);
  assign last_word = (word_cnt == LAST_WORD);
  assign last_pass = (pass_cnt == passes_q - PASS_W'(1));

  assign rom_addr = word_cnt;
  assign w_valid  = (state == EMIT);
  assign w_data   = (state == EMIT) ? lane_sel(hold, byte_cnt) : 8'sd0;
  assign w_idx    = (state == EMIT) ? byte_cnt : 2'd0;
  assign w_last   = (state == EMIT) && last_byte && last_word;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: state_nxt = EMIT;
      EMIT: begin
        if (hs && last_byte) begin
          if (!last_word || !last_pass) state_nxt = LOAD;
          else                          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // abort wins over start and over a handshake in the same cycle
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state    <= IDLE;
      word_cnt <= '0;
      byte_cnt <= '0;
      pass_cnt <= '0;
      passes_q <= '0;
      hold     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            passes_q <= (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
            word_cnt <= '0;
            byte_cnt <= '0;
            pass_cnt <= '0;
          end
        end
        LOAD: begin
          hold     <= $signed(rom_dout);
          byte_cnt <= '0;
        end
        EMIT: begin
          if (hs) begin
            if (!last_byte) begin
              byte_cnt <= byte_cnt + 2'd1;
            end else if (!last_word) begin
              word_cnt <= word_cnt + ADDR_W'(1);
            end else if (!last_pass) begin
              word_cnt <= '0;
              pass_cnt <= pass_cnt + PASS_W'(1);
            end
          end
        end
        DONE: word_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mapping_weight_sequencer.sv
// Scoreboard bench for mapping_weight_sequencer: stimulus queues expected weight bytes,
// a negedge monitor pops and compares them on every accepted handshake.
module tb_mapping_weight_sequencer;

  logic              clk = 1'b0;
  logic              rst, start, abort, w_ready;
  logic [3:0]        cfg_passes;
  logic [2:0]        rom_addr;
  logic [23:0]       rom_dout;
  logic signed [7:0] w_data;
  logic              w_valid, w_last, busy, done;
  logic [1:0]        w_idx;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] idx;
    logic       last;
    logic [2:0] addr;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] rom [0:7];
  int          tests = 0, fails = 0;
  int          cyc = 0;
  int          hs_cnt, done_cnt, last_cnt, busy_cnt, first_valid_cyc, done_cyc;
  logic        prev_stall = 1'b0;
  logic [7:0]  held_data;
  logic [1:0]  held_idx;
  logic        held_last;

  mapping_weight_sequencer #(.NUM_WORDS(6), .ADDR_W(3), .PASS_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_passes(cfg_passes),
    .rom_addr(rom_addr), .rom_dout(rom_dout), .w_data(w_data), .w_valid(w_valid),
    .w_ready(w_ready), .w_last(w_last), .w_idx(w_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    rom[0] = 24'h10D3E8; rom[1] = 24'h7FD6B5; rom[2] = 24'hE87F7F;
    rom[3] = 24'h10D3E8; rom[4] = 24'h7FD6B5; rom[5] = 24'hE87F7F;
    rom[6] = 24'h0;      rom[7] = 24'h0;
  end
  assign rom_dout = (rom_addr < 3'd6) ? rom[rom_addr] : 24'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pops, stall-hold checks and event counters
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (w_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (busy) chk("rom_addr_range", {31'd0, rom_addr <= 3'd5}, 32'd1);
    if (prev_stall) begin
      chk("hold_valid", {31'd0, w_valid}, 32'd1);
      chk("hold_data_idx_last", {21'd0, w_data, w_idx, w_last}, {21'd0, held_data, held_idx, held_last});
    end
    if (w_valid && w_ready && !abort && !rst) begin
      hs_cnt++;
      if (w_last) last_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_byte", {24'd0, w_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("w_data", {24'd0, w_data}, {24'd0, e.data});
        chk("w_idx_last_addr", {26'd0, w_idx, w_last, rom_addr}, {26'd0, e.idx, e.last, e.addr});
      end
    end
    prev_stall = w_valid && !w_ready && !abort && !rst;
    held_data  = w_data;
    held_idx   = w_idx;
    held_last  = w_last;
  end

  task automatic clear_counts();
    hs_cnt = 0; done_cnt = 0; last_cnt = 0; busy_cnt = 0;
    first_valid_cyc = -1; done_cyc = -1;
  endtask

  task automatic push_pass();
    for (int w = 0; w < 6; w++)
      for (int b = 0; b < 3; b++) begin
        exp_t e;
        logic [23:0] word;
        word   = rom[w];
        e.data = (b == 0) ? word[23:16] : (b == 1) ? word[15:8] : word[7:0];
        e.idx  = 2'(b);
        e.last = (w == 5 && b == 2);
        e.addr = 3'(w);
        sb.push_back(e);
      end
  endtask

  // Returns the cycle in which start was high
  task automatic pulse_start(input logic [3:0] passes, output int t0);
    @(posedge clk); #1;
    start = 1'b1; cfg_passes = passes; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input string name, input logic [3:0] passes, input int eff,
                     input bit rnd_ready, input bit mid_start, input bit timing);
    int t0;
    bit seen;
    clear_counts();
    for (int p = 0; p < eff; p++) push_pass();
    pulse_start(passes, t0);
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk); #1;
      if (rnd_ready) w_ready = 1'($urandom_range(0, 1));
      start = mid_start && (cyc == t0 + 7);
      seen = (done_cnt != 0);
    end
    w_ready = 1'b1; start = 1'b0;
    chk({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({name, "_done_count"}, done_cnt, 32'd1);
    chk({name, "_bytes"}, hs_cnt, 32'(18 * eff));
    chk({name, "_last_count"}, last_cnt, 32'(eff));
    chk({name, "_sb_empty"}, sb.size(), 32'd0);
    if (timing) begin
      chk({name, "_first_valid"}, first_valid_cyc - t0, 32'd2);
      chk({name, "_done_cycle"}, done_cyc - t0, 32'd25);
      chk({name, "_busy_cycles"}, busy_cnt, 32'd25);
    end
    sb.delete();
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_outs"}, {18'd0, w_data, w_valid, w_last, w_idx, busy, done, rom_addr},
        32'd0);
  endtask

  initial begin
    int t0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; w_ready = 1'b1; cfg_passes = 4'd1;
    clear_counts();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle("reset");

    run("p1", 4'd1, 1, 1'b0, 1'b0, 1'b1);
    run("p0", 4'd0, 1, 1'b0, 1'b0, 1'b1);
    run("p3", 4'd3, 3, 1'b0, 1'b0, 1'b0);
    run("rnd_ready", 4'd2, 2, 1'b1, 1'b0, 1'b0);
    run("mid_start", 4'd1, 1, 1'b0, 1'b1, 1'b1);

    // Abort while the 7th byte (E8, word 2) is presented: it must not be consumed
    clear_counts();
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      logic [23:0] word;
      word   = rom[i / 3];
      e.data = (i % 3 == 0) ? word[23:16] : (i % 3 == 1) ? word[15:8] : word[7:0];
      e.idx  = 2'(i % 3);
      e.last = 1'b0;
      e.addr = 3'(i / 3);
      sb.push_back(e);
    end
    pulse_start(4'd1, t0);
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    chk("abort_byte7", {22'd0, w_valid, w_data, w_idx}, {22'd0, 1'b1, 8'hE8, 2'd0});
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk_idle("abort_next");
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("abort_no_done", done_cnt, 32'd0);
    chk("abort_bytes", hs_cnt, 32'd6);
    chk("abort_sb_empty", sb.size(), 32'd0);
    sb.delete();
    run("after_abort", 4'd1, 1, 1'b0, 1'b0, 1'b1);

    // Start and abort together in IDLE: stays idle
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk_idle("start_abort_idle");

    // Synchronous reset mid-EMIT (word 1, byte 0): 3 bytes go out, then all outputs clear
    clear_counts();
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.data = (i == 0) ? 8'h10 : (i == 1) ? 8'hD3 : 8'hE8;
      e.idx  = 2'(i);
      e.last = 1'b0;
      e.addr = 3'd0;
      sb.push_back(e);
    end
    pulse_start(4'd1, t0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_idle("rst_mid");
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("rst_no_done", done_cnt, 32'd0);
    chk("rst_bytes", hs_cnt, 32'd3);
    sb.delete();
    run("after_rst", 4'd1, 1, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
